// File: rtl/fsbm_pkg.sv
// Shared definitions for the full-search block matcher.
// Holds default geometry, the SAD-array state encoding and lane packing
// helpers so that the SAD array and the compare stage slice their packed
// lane buses identically.
package fsbm_pkg;

  localparam int unsigned PIX_W_DEF    = 8;
  localparam int unsigned SUM_W_DEF    = 12;
  localparam int unsigned NUM_CAND_DEF = 16;
  localparam int unsigned BLK_PIX_DEF  = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_e;

  // Low bit index of lane `lane` in a bus packed with `w` bits per lane.
  function automatic int unsigned lane_lo(input int unsigned lane, input int unsigned w);
    return lane * w;
  endfunction

  // Counter width for a block of n pixels; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sad_pe.sv
// One SAD lane: absolute difference of two unsigned pixels added into a
// saturating accumulator.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   clr_i          clear the accumulator (takes priority over en_i)
//   en_i           add |cur_i - ref_i| this cycle
//   cur_i, ref_i   current and reference pixels
//   next_o         accumulator plus this cycle's difference (saturated);
//                  lets the parent capture the final sum on the last edge
module sad_pe
  import fsbm_pkg::*;
#(
  parameter int unsigned PIX_W = PIX_W_DEF,
  parameter int unsigned SUM_W = SUM_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [PIX_W-1:0] cur_i,
  input  logic [PIX_W-1:0] ref_i,
  output logic [SUM_W-1:0] next_o
);

  logic [PIX_W-1:0] diff;
  logic [SUM_W:0]   sum_wide;
  logic [SUM_W-1:0] acc_q;
  logic [SUM_W-1:0] acc_d;

  always_comb begin
    diff     = (cur_i >= ref_i) ? (cur_i - ref_i) : (ref_i - cur_i);
    // One extra bit catches the carry that signals saturation.
    sum_wide = {1'b0, acc_q} + (SUM_W+1)'(diff);
    next_o   = sum_wide[SUM_W] ? '1 : sum_wide[SUM_W-1:0];
  end

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = next_o;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/sad_array.sv
// Parallel SAD array: accumulates |cur - ref[i]| over a 4x4 block for
// NUM_CAND candidate positions and presents all sums with a one-cycle strobe.
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   start        begin a new block (accepted in IDLE only)
//   pix_valid    pixel pair valid (accepted in ACCUM only)
//   cur_pix      current-block pixel
//   ref_pix      reference pixels, lane i at [i*PIX_W +: PIX_W]
//   sums         registered SAD results, lane i at [i*SUM_W +: SUM_W]
//   sums_valid   one-cycle pulse when sums are updated
//   busy         high while accumulating
module sad_array
  import fsbm_pkg::*;
#(
  parameter int unsigned NUM_CAND = NUM_CAND_DEF,
  parameter int unsigned PIX_W    = PIX_W_DEF,
  parameter int unsigned SUM_W    = SUM_W_DEF,
  parameter int unsigned BLK_PIX  = BLK_PIX_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      pix_valid,
  input  logic [PIX_W-1:0]          cur_pix,
  input  logic [NUM_CAND*PIX_W-1:0] ref_pix,
  output logic [NUM_CAND*SUM_W-1:0] sums,
  output logic                      sums_valid,
  output logic                      busy
);

  localparam int unsigned      CNT_W    = cnt_width(BLK_PIX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLK_PIX - 1);

  state_e                    state_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [NUM_CAND*SUM_W-1:0] sums_q;
  logic                      sums_valid_q;
  logic [NUM_CAND*SUM_W-1:0] lane_next;
  logic                      clr;
  logic                      accept;

  assign clr    = (state_q == ST_IDLE) && start;
  assign accept = (state_q == ST_ACCUM) && pix_valid;

  for (genvar g = 0; g < NUM_CAND; g++) begin : g_lane
    sad_pe #(
      .PIX_W (PIX_W),
      .SUM_W (SUM_W)
    ) u_pe (
      .clk_i  (clk),
      .rst_ni (rst),
      .clr_i  (clr),
      .en_i   (accept),
      .cur_i  (cur_pix),
      .ref_i  (ref_pix[lane_lo(g, PIX_W) +: PIX_W]),
      .next_o (lane_next[lane_lo(g, SUM_W) +: SUM_W])
    );
  end

  // The final pixel's difference is folded in via lane_next, so the sums
  // register captures the complete block on the completion edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      sums_q       <= '0;
      sums_valid_q <= 1'b0;
    end else begin
      sums_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            cnt_q   <= '0;
            state_q <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (pix_valid) begin
            if (cnt_q == CNT_LAST) begin
              cnt_q        <= '0;
              sums_q       <= lane_next;
              sums_valid_q <= 1'b1;
              state_q      <= ST_IDLE;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign sums       = sums_q;
  assign sums_valid = sums_valid_q;
  assign busy       = (state_q == ST_ACCUM);

endmodule

// File: tb/tb_sad_array.sv
module tb_sad_array;

  localparam int NC = 16;
  localparam int PW = 8;
  localparam int SW = 12;
  localparam int BP = 16;

  logic               clk;
  logic               rst;
  logic               start_s;
  logic               pv_s;
  logic [PW-1:0]      cur_s;
  logic [NC*PW-1:0]   ref_s;
  logic [NC*SW-1:0]   sums;
  logic               sums_valid;
  logic               busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]       cur_arr [BP];
  logic [7:0]       ref_arr [BP][NC];
  logic [NC*SW-1:0] held_flat;

  sad_array dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start_s),
    .pix_valid  (pv_s),
    .cur_pix    (cur_s),
    .ref_pix    (ref_s),
    .sums       (sums),
    .sums_valid (sums_valid),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (observed timeout, required finish)");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [NC*SW-1:0] obs, input logic [NC*SW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_inputs();
    cur_s = 8'($urandom);
    for (int l = 0; l < NC; l++) ref_s[l*PW +: PW] = 8'($urandom);
  endtask

  task automatic fill_uniform(input int c, input int rbase, input int rstep);
    for (int p = 0; p < BP; p++) begin
      cur_arr[p] = 8'(c);
      for (int l = 0; l < NC; l++) ref_arr[p][l] = 8'(rbase + rstep * l);
    end
  endtask

  task automatic fill_random();
    for (int p = 0; p < BP; p++) begin
      cur_arr[p] = 8'($urandom);
      for (int l = 0; l < NC; l++) ref_arr[p][l] = 8'($urandom);
    end
  endtask

  // Starts a block, feeds its pixels (optionally with idle gaps that may
  // carry a spurious start), checks holding behaviour throughout, and checks
  // the completion cycle. Leaves the bench in the sums_valid cycle.
  task automatic run_block(input int max_gap, input bit mid_start, output int ncyc);
    int               exp_s [NC];
    logic [NC*SW-1:0] exp_flat;
    int               gaps;
    for (int l = 0; l < NC; l++) begin
      int acc;
      acc = 0;
      for (int p = 0; p < BP; p++) begin
        int d;
        d = int'(cur_arr[p]) - int'(ref_arr[p][l]);
        if (d < 0) d = -d;
        acc += d;
      end
      if (acc > (1 << SW) - 1) acc = (1 << SW) - 1;
      exp_s[l] = acc;
      exp_flat[l*SW +: SW] = SW'(acc);
    end

    start_s = 1'b1;
    pv_s    = 1'b1;          // ignored while idle
    rnd_inputs();
    tick();
    ncyc    = 1;
    start_s = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("valid_after_start", sums_valid, 0);
    chk("sums_hold_start", sums, held_flat);

    for (int p = 0; p < BP; p++) begin
      gaps = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      for (int g = 0; g < gaps; g++) begin
        pv_s    = 1'b0;
        start_s = mid_start;
        rnd_inputs();
        tick();
        ncyc++;
        start_s = 1'b0;
        chk("valid_in_gap", sums_valid, 0);
        chk("busy_in_gap", busy, 1);
      end
      pv_s  = 1'b1;
      cur_s = cur_arr[p];
      for (int l = 0; l < NC; l++) ref_s[l*PW +: PW] = ref_arr[p][l];
      tick();
      ncyc++;
      if (p < BP - 1) begin
        chk("valid_mid_block", sums_valid, 0);
        chk("sums_hold_mid", sums, held_flat);
      end
    end
    pv_s = 1'b0;
    chk("valid_at_done", sums_valid, 1);
    chk("busy_at_done", busy, 0);
    for (int l = 0; l < NC; l++) begin
      chk($sformatf("sum_lane%0d", l), sums[l*SW +: SW], exp_s[l]);
    end
    held_flat = exp_flat;
  endtask

  task automatic idle_after_block();
    pv_s    = 1'b0;
    start_s = 1'b0;
    tick();
    chk("valid_drops", sums_valid, 0);
    chk("busy_idle", busy, 0);
    chk("sums_hold_idle", sums, held_flat);
  endtask

  int ncyc;

  initial begin
    rst       = 1'b1;
    start_s   = 1'b0;
    pv_s      = 1'b0;
    cur_s     = '0;
    ref_s     = '0;
    held_flat = '0;

    // Reset state
    #2 rst = 1'b0;
    #1;
    chk("rst_sums", sums, 0);
    chk("rst_valid", sums_valid, 0);
    chk("rst_busy", busy, 0);
    tick();
    tick();
    rst = 1'b1;

    // Idle with pix_valid toggling, no start
    for (int i = 0; i < 10; i++) begin
      pv_s = 1'(i % 2);
      rnd_inputs();
      tick();
      chk("idle_valid", sums_valid, 0);
      chk("idle_busy", busy, 0);
      chk("idle_sums", sums, 0);
    end
    pv_s = 1'b0;

    // cur=100, ref lane i = 100+i -> sum i = 16*i
    fill_uniform(100, 100, 1);
    run_block(0, 1'b0, ncyc);
    chk("latency_contig", ncyc, 17);
    chk("sum15_240", sums[15*SW +: SW], 240);
    idle_after_block();

    // Max case, both directions
    fill_uniform(255, 0, 0);
    run_block(0, 1'b0, ncyc);
    idle_after_block();
    fill_uniform(0, 255, 0);
    run_block(0, 1'b0, ncyc);
    chk("sum0_4080", sums[0 +: SW], 4080);
    idle_after_block();

    // Gapped delivery with spurious starts, same data as contiguous case
    fill_uniform(100, 100, 1);
    run_block(2, 1'b1, ncyc);
    chk("sum15_gapped", sums[15*SW +: SW], 240);
    idle_after_block();

    // Back-to-back: random block, then cur=10 ref=12 started in valid cycle
    fill_random();
    run_block(0, 1'b0, ncyc);
    fill_uniform(10, 12, 0);
    run_block(0, 1'b0, ncyc);
    chk("b2b_latency", ncyc, 17);
    chk("b2b_sum7", sums[7*SW +: SW], 32);
    idle_after_block();

    // Async reset after 7 pixels, asserted between edges
    fill_random();
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    for (int p = 0; p < 7; p++) begin
      pv_s = 1'b1;
      rnd_inputs();
      tick();
    end
    chk("busy_before_abort", busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_sums", sums, 0);
    chk("abort_valid", sums_valid, 0);
    held_flat = '0;
    pv_s = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      pv_s = 1'b1;
      rnd_inputs();
      tick();
      chk("post_abort_valid", sums_valid, 0);
      chk("post_abort_busy", busy, 0);
    end
    pv_s = 1'b0;
    fill_random();
    run_block(0, 1'b0, ncyc);
    idle_after_block();

    // Random blocks with random gaps
    for (int b = 0; b < 4; b++) begin
      fill_random();
      run_block(3, 1'(b % 2), ncyc);
      if (b % 2 == 1) idle_after_block();
    end
    idle_after_block();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sad_array.md
Name: sad_array

Overview:
- Produces the 16 candidate SAD values that feed the minimum-SAD compare stage of the full-search block matcher.
- Accumulates the sum of absolute differences for one 4x4 current block against 16 candidate reference positions in parallel, one pixel per accepted cycle.
- After the last pixel, it presents all 16 sums together with a one-cycle valid strobe.
- It sits between the pixel fetch/address generator and the compare stage.

Parameters:
- NUM_CAND, 16, number of candidate positions (lanes) processed in parallel.
- PIX_W, 8, pixel width in bits, unsigned.
- SUM_W, 12, width of each SAD sum. Default max is 16*255 = 4080, so no overflow at defaults.
- BLK_PIX, 16, pixels per block (4x4).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset. Asserted (0) clears all state immediately.
- start  in  1  one-cycle request to begin a new block. Honoured only in IDLE.
- pix_valid  in  1  current and reference pixels valid this cycle. Honoured only in ACCUM.
- cur_pix  in  PIX_W  current-block pixel.
- ref_pix  in  NUM_CAND*PIX_W  reference pixels. Lane i is at [i*PIX_W +: PIX_W].
- sums  out  NUM_CAND*SUM_W  registered SAD results. Lane i is at [i*SUM_W +: SUM_W] and wires to compare input sum<i>.
- sums_valid  out  1  one-cycle pulse; sums are new this cycle.
- busy  out  1  high while in ACCUM.

Behaviour:
- Reset (rst=0, async):
  - State goes to IDLE; pixel counter = 0.
  - All accumulators = 0, sums = 0, sums_valid = 0, busy = 0.
  - Reset mid-block discards the partial block; no sums_valid is produced for it.
- State machine, two states:
  - IDLE: start=1 clears all accumulators and the counter, then moves to ACCUM on that edge. pix_valid is ignored in IDLE.
  - ACCUM: each cycle with pix_valid=1, every lane i adds |cur_pix - ref_pix[i]| and the counter increments. Cycles with pix_valid=0 hold all state. start is ignored in ACCUM.
- Completion (the BLK_PIX-th accepted pixel, counter = BLK_PIX-1):
  - On that edge, sums[i] is loaded with acc[i] + |diff_i| directly, so the final add is not lost.
  - sums_valid goes to 1 and the state returns to IDLE.
  - Result: the last pixel accepted in cycle k gives sums and sums_valid=1 visible in cycle k+1. sums_valid drops in cycle k+2.
- Latency:
  - start in cycle 0 puts busy=1 from cycle 1.
  - The earliest first pixel is in cycle 1. The earliest sums_valid is cycle 1+BLK_PIX.
- Back-to-back: start is accepted in the cycle where sums_valid=1 (state is IDLE), giving zero bubble between blocks.
- sums hold their value until the next block completes; they are not cleared by start.
- Arithmetic:
  - Absolute difference is unsigned PIX_W-bit, computed as a-b if a>=b else b-a.
  - The result is zero-extended to SUM_W before adding.
  - Accumulators saturate at 2^SUM_W-1 if a parameter override makes overflow possible; this never triggers at defaults.
- Counter: width is clog2(BLK_PIX). It wraps to 0 at completion and never exceeds BLK_PIX-1.

Decomposition:
- Shared package fsbm_pkg holds:
  - The defaults PIX_W=8, SUM_W=12, NUM_CAND=16, BLK_PIX=16.
  - The state encoding (IDLE=0, ACCUM=1).
  - Lane slice helpers/constants, so compare and sad_array agree on packing.
- One sub-module, sad_pe: one lane containing the abs-diff, the saturating accumulator, and the clear/enable inputs. It is instantiated NUM_CAND times via generate. Counter and FSM stay in sad_array.

Test Plan:
- Reset then idle, with pix_valid toggling and no start: sums=0, sums_valid never 1, busy=0.
- start, then 16 pixels with cur_pix=100 and ref lane i = 100+i: sum[i]=16*i (e.g. sum15=240), sums_valid exactly one cycle after the 16th pixel.
- Max case, cur_pix=255 and all refs 0, 16 pixels: every sum=4080 with no wrap. Then cur=0, ref=255 gives the same 4080.
- pix_valid gaps: 16 pixels spread over 30 cycles with random idle cycles give the same sums as the contiguous case. start pulsed mid-block is ignored (sums unchanged by it).
- Back-to-back: second start in the sums_valid cycle; block 2 (cur=10, ref=12) gives all sums=32 at exactly cycle 17 after block-1 sums_valid, and block-1 sums hold until then.
- Async reset asserted after 7 pixels, between clock edges: outputs clear immediately. A new start plus 16 pixels then yields correct sums with no residue from the aborted block.
